ddr3_dfi_rdcap: RTL and testbench
=================================

Name: ddr3_dfi_rdcap

Overview:
- Read-capture and alignment stage between the DDR3 PHY read path and the DFI read-data inputs of the memory controller top (`dfi_rvld_i`, `dfi_last_i`, `dfi_data_i`).
- Consumes the controller's `dfi_rden_o` strobe and delays it by a calibratable number of cycles to form the capture window.
- Samples raw PHY read data inside that window, frames it into bursts with a last marker, and flags framing errors.
- Runtime-adjustable delay supports read-levelling calibration without a rebuild.

Parameters:
- WIDTH, 32, PHY read-data width (two DQ edges per clock).
- BURST_BEATS, 4, data beats per read burst (BL8 on the PHY side); power of two, >=2.
- DELAY_BITS, 4, width of the delay setting; maximum delay is 2^DELAY_BITS-1.
- DEFAULT_DELAY, 5, delay loaded at reset (CL-derived for DLL-off at 100 MHz).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_load_i  in  1  request to load a new delay value.
- cfg_delay_i  in  DELAY_BITS  new delay value, sampled with cfg_load_i.
- cfg_delay_o  out  DELAY_BITS  currently active delay.
- dfi_rden_i  in  1  read-enable from controller; high for one cycle per expected beat.
- phy_data_i  in  WIDTH  raw captured read data from the PHY, valid every cycle.
- dfi_rvld_o  out  1  read-data valid to the controller.
- dfi_last_o  out  1  last beat of the burst; qualified by dfi_rvld_o.
- dfi_data_o  out  WIDTH  read data to the controller.
- busy_o  out  1  a read is in flight (delay line or burst counter non-idle).
- err_o  out  1  sticky framing error.

Behaviour:
- Reset values: dfi_rvld_o=0, dfi_last_o=0, dfi_data_o=0, busy_o=0, err_o=0, cfg_delay_o=DEFAULT_DELAY. The delay line, burst counter and pending-load flag are all cleared.
- Delay line: a 2^DELAY_BITS-1 deep shift register of dfi_rden_i.
  - tap = dfi_rden_i when delay_q=0, otherwise shift-register stage delay_q.
- Capture: when tap=1, register phy_data_i into dfi_data_o and assert dfi_rvld_o on the next cycle.
  - Latency from dfi_rden_i to dfi_rvld_o is exactly delay_q+1 cycles.
  - When tap=0, dfi_rvld_o=0 and dfi_data_o holds its last value.
- Beat counter: $clog2(BURST_BEATS) bits, advances on each captured beat and wraps modulo BURST_BEATS.
  - dfi_last_o=1 together with the beat captured while the counter equals BURST_BEATS-1.
  - Back-to-back bursts with no gap are legal; the counter wraps 3->0 seamlessly.
- Framing error: if tap=0 while the counter is non-zero (a burst was cut short), set err_o, which then stays set until reset. The counter returns to 0 and no last is emitted for the partial burst.
- busy_o = OR of the delay line, the counter being non-zero, and the pending-load flag.
- Delay update (FSM states IDLE and PEND):
  - IDLE + cfg_load_i with the delay line all-zero and counter=0: delay_q <= cfg_delay_i next cycle.
  - IDLE + cfg_load_i while in flight: latch cfg_delay_i, go to PEND.
  - PEND: once the delay line is all-zero and counter=0, apply the latched value and return to IDLE.
  - A cfg_load_i arriving in PEND overwrites the latched value; last write wins.
- dfi_rden_i asserted during PEND is captured with the old delay. The controller must not issue reads during calibration; there is no stall back-pressure.
- No ready signal: the controller read path must accept every beat.
- Synchronous reset mid-burst discards all in-flight beats, and no rvld is produced after reset.

Test Plan:
- Reset, then 4-cycle dfi_rden_i pulse with phy_data_i=0xA0..0xA3 when tap high, DEFAULT_DELAY=5 -> rvld high for 4 cycles starting 6 cycles after the first rden; data A0,A1,A2,A3; last only with A3; err_o=0.
- Two back-to-back 4-beat bursts (8 contiguous rden cycles) -> 8 contiguous rvld cycles; last on beats 4 and 8.
- cfg_load_i with cfg_delay_i=0 while idle, then one burst -> rvld 1 cycle after rden; cfg_delay_o=0.
- cfg_load_i with cfg_delay_i=9 issued mid-burst -> that burst completes at delay 5; cfg_delay_o changes to 9 only after busy_o falls; the next burst arrives 10 cycles after rden.
- 2-cycle rden pulse -> 2 rvld beats, no last, err_o=1 and stays set; a following full burst frames correctly with last on its 4th beat.
- Assert reset while beat 2 of a burst is in flight -> no further rvld; all outputs at reset values the cycle after reset is sampled.

Source files
------------

// File: rtl/ddr3_dfi_rdcap.sv
// DDR3 read-capture and alignment stage.
// Delays the controller read-enable by a calibratable number of cycles to
// form the capture window, samples PHY read data inside it, frames the
// beats into bursts with a last marker and flags truncated bursts.
module ddr3_dfi_rdcap #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned BURST_BEATS   = 4,
   parameter int unsigned DELAY_BITS    = 4,
   parameter int unsigned DEFAULT_DELAY = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_load_i,
   input  logic [DELAY_BITS-1:0] cfg_delay_i,
   output logic [DELAY_BITS-1:0] cfg_delay_o,
   input  logic                  dfi_rden_i,
   input  logic [WIDTH-1:0]      phy_data_i,
   output logic                  dfi_rvld_o,
   output logic                  dfi_last_o,
   output logic [WIDTH-1:0]      dfi_data_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int unsigned DEPTH = (1 << DELAY_BITS) - 1;
   localparam int unsigned CNT_W = $clog2(BURST_BEATS);
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_BEATS - 1);
   localparam logic [DELAY_BITS-1:0] RST_DELAY = DELAY_BITS'(DEFAULT_DELAY);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [DEPTH-1:0]      sr_q, sr_d;
   logic [DELAY_BITS-1:0] delay_q, delay_d;
   logic [DELAY_BITS-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rvld_q, rvld_d;
   logic                  last_q, last_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  err_q, err_d;

   // Tap vector: index 0 is the undelayed strobe, index k is the strobe k cycles ago.
   logic [DEPTH:0] taps;
   logic           tap;
   logic           drained;

   assign taps    = {sr_q, dfi_rden_i};
   assign tap     = taps[delay_q];
   assign drained = (sr_q == '0) && (cnt_q == '0);

   // Read-enable delay line.
   always_comb begin
      sr_d = {sr_q[DEPTH-2:0], dfi_rden_i};
   end

   // Capture, burst framing and sticky truncation error.
   always_comb begin
      rvld_d = tap;
      last_d = tap && (cnt_q == LAST_BEAT);
      data_d = data_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (tap) begin
         data_d = phy_data_i;
         cnt_d  = cnt_q + CNT_W'(1);
      end else if (cnt_q != '0) begin
         err_d = 1'b1;
         cnt_d = '0;
      end
   end

   // Delay-update FSM: apply immediately when drained, otherwise hold pending.
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_load_i) begin
               if (drained) begin
                  delay_d = cfg_delay_i;
               end else begin
                  pend_d  = cfg_delay_i;
                  state_d = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (cfg_load_i) begin
               pend_d = cfg_delay_i;
            end
            if (drained) begin
               delay_d = cfg_load_i ? cfg_delay_i : pend_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         delay_q <= RST_DELAY;
         pend_q  <= '0;
         cnt_q   <= '0;
         rvld_q  <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         delay_q <= delay_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         rvld_q  <= rvld_d;
         last_q  <= last_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign cfg_delay_o = delay_q;
   assign dfi_rvld_o  = rvld_q;
   assign dfi_last_o  = last_q;
   assign dfi_data_o  = data_q;
   assign err_o       = err_q;
   assign busy_o      = (sr_q != '0) || (cnt_q != '0) || (state_q == ST_PEND);

endmodule

// File: tb/tb_ddr3_dfi_rdcap.sv
// Directed bench for ddr3_dfi_rdcap: reset, single and back-to-back bursts,
// delay reload when idle and in flight, truncated burst and mid-burst reset.
module tb_ddr3_dfi_rdcap;

   logic        clock;
   logic        reset;
   logic        cfg_load_i;
   logic [3:0]  cfg_delay_i;
   logic [3:0]  cfg_delay_o;
   logic        dfi_rden_i;
   logic [31:0] phy_data_i;
   logic        dfi_rvld_o;
   logic        dfi_last_o;
   logic [31:0] dfi_data_o;
   logic        busy_o;
   logic        err_o;

   int checks;
   int passes;

   ddr3_dfi_rdcap dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_load_i  (cfg_load_i),
      .cfg_delay_i (cfg_delay_i),
      .cfg_delay_o (cfg_delay_o),
      .dfi_rden_i  (dfi_rden_i),
      .phy_data_i  (phy_data_i),
      .dfi_rvld_o  (dfi_rvld_o),
      .dfi_last_o  (dfi_last_o),
      .dfi_data_o  (dfi_data_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Step i of an n-beat read: rden for steps [0,n), burst data presented at steps [d,d+n).
   task automatic drive(input int i, input int n, input int d, input logic [31:0] base);
      dfi_rden_i = (i < n);
      if (i >= d && i < d + n) phy_data_i = base + 32'(i - d);
      else                     phy_data_i = 32'hEE00_0000 | 32'(i);
   endtask

   task automatic idle(input int k);
      dfi_rden_i = 1'b0;
      cfg_load_i = 1'b0;
      for (int j = 0; j < k; j++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; cfg_load_i = 1'b0; cfg_delay_i = '0;
      dfi_rden_i = 1'b0; phy_data_i = 32'h1234_5678;
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++; if (dfi_rvld_o !== 1'b0) $display("FAIL reset_rvld got %b want 0", dfi_rvld_o); else passes++;
      checks++; if (dfi_last_o !== 1'b0) $display("FAIL reset_last got %b want 0", dfi_last_o); else passes++;
      checks++; if (dfi_data_o !== 32'h0) $display("FAIL reset_data got %h want 0", dfi_data_o); else passes++;
      checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else passes++;
      checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else passes++;
      checks++; if (cfg_delay_o !== 4'd5) $display("FAIL reset_delay got %0d want 5", cfg_delay_o); else passes++;
   endtask

   task automatic test_single_burst();
      logic v;
      for (int i = 0; i < 13; i++) begin
         drive(i, 4, 5, 32'hA0);
         tick();
         v = (i >= 5 && i < 9);
         checks++; if (dfi_rvld_o !== v) $display("FAIL single_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== (i == 8)) $display("FAIL single_last step %0d got %b want %b", i, dfi_last_o, (i == 8)); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'hA0 + 32'(i - 5)) $display("FAIL single_data step %0d got %h want %h", i, dfi_data_o, 32'hA0 + 32'(i - 5)); else passes++;
         end
         if (i == 5) begin
            checks++; if (busy_o !== 1'b1) $display("FAIL single_busy got %b want 1", busy_o); else passes++;
         end
      end
      checks++; if (err_o !== 1'b0) $display("FAIL single_err got %b want 0", err_o); else passes++;
      idle(20);
      checks++; if (busy_o !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy_o); else passes++;
   endtask

   task automatic test_back_to_back();
      logic v, l;
      for (int i = 0; i < 15; i++) begin
         drive(i, 8, 5, 32'hB0);
         tick();
         v = (i >= 5 && i < 13);
         l = (i == 8) || (i == 12);
         checks++; if (dfi_rvld_o !== v) $display("FAIL b2b_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== l) $display("FAIL b2b_last step %0d got %b want %b", i, dfi_last_o, l); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'hB0 + 32'(i - 5)) $display("FAIL b2b_data step %0d got %h want %h", i, dfi_data_o, 32'hB0 + 32'(i - 5)); else passes++;
         end
      end
      checks++; if (err_o !== 1'b0) $display("FAIL b2b_err got %b want 0", err_o); else passes++;
      idle(20);
   endtask

   task automatic test_load_idle();
      logic v;
      cfg_load_i = 1'b1; cfg_delay_i = 4'd0;
      tick();
      cfg_load_i = 1'b0;
      checks++; if (cfg_delay_o !== 4'd0) $display("FAIL load_idle_delay got %0d want 0", cfg_delay_o); else passes++;
      checks++; if (busy_o !== 1'b0) $display("FAIL load_idle_busy got %b want 0", busy_o); else passes++;
      for (int i = 0; i < 7; i++) begin
         drive(i, 4, 0, 32'hC0);
         tick();
         v = (i < 4);
         checks++; if (dfi_rvld_o !== v) $display("FAIL d0_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== (i == 3)) $display("FAIL d0_last step %0d got %b want %b", i, dfi_last_o, (i == 3)); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'hC0 + 32'(i)) $display("FAIL d0_data step %0d got %h want %h", i, dfi_data_o, 32'hC0 + 32'(i)); else passes++;
         end
      end
      idle(20);
   endtask

   task automatic test_load_pending();
      logic v;
      bit   fell;
      cfg_load_i = 1'b1; cfg_delay_i = 4'd5;
      tick();
      cfg_load_i = 1'b0;
      checks++; if (cfg_delay_o !== 4'd5) $display("FAIL pend_restore got %0d want 5", cfg_delay_o); else passes++;
      for (int i = 0; i < 13; i++) begin
         drive(i, 4, 5, 32'hD0);
         cfg_load_i  = (i == 1);
         cfg_delay_i = 4'd9;
         tick();
         v = (i >= 5 && i < 9);
         checks++; if (dfi_rvld_o !== v) $display("FAIL pend_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== (i == 8)) $display("FAIL pend_last step %0d got %b want %b", i, dfi_last_o, (i == 8)); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'hD0 + 32'(i - 5)) $display("FAIL pend_data step %0d got %h want %h", i, dfi_data_o, 32'hD0 + 32'(i - 5)); else passes++;
         end
         checks++; if (cfg_delay_o !== 4'd5) $display("FAIL pend_old_delay step %0d got %0d want 5", i, cfg_delay_o); else passes++;
      end
      cfg_load_i = 1'b0;
      dfi_rden_i = 1'b0;
      fell = 1'b0;
      for (int k = 0; k < 40 && !fell; k++) begin
         if (busy_o === 1'b0) begin
            fell = 1'b1;
         end else begin
            checks++; if (cfg_delay_o !== 4'd5) $display("FAIL pend_busy_delay got %0d want 5", cfg_delay_o); else passes++;
            tick();
         end
      end
      checks++; if (!fell) $display("FAIL pend_busy_timeout busy got %b want 0", busy_o); else passes++;
      checks++; if (cfg_delay_o !== 4'd9) $display("FAIL pend_new_delay got %0d want 9", cfg_delay_o); else passes++;
      for (int i = 0; i < 15; i++) begin
         drive(i, 4, 9, 32'hE0);
         tick();
         v = (i >= 9 && i < 13);
         checks++; if (dfi_rvld_o !== v) $display("FAIL d9_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== (i == 12)) $display("FAIL d9_last step %0d got %b want %b", i, dfi_last_o, (i == 12)); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'hE0 + 32'(i - 9)) $display("FAIL d9_data step %0d got %h want %h", i, dfi_data_o, 32'hE0 + 32'(i - 9)); else passes++;
         end
      end
      idle(20);
   endtask

   task automatic test_short_burst();
      logic v;
      for (int i = 0; i < 14; i++) begin
         drive(i, 2, 9, 32'hF0);
         tick();
         v = (i >= 9 && i < 11);
         checks++; if (dfi_rvld_o !== v) $display("FAIL short_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== 1'b0) $display("FAIL short_last step %0d got %b want 0", i, dfi_last_o); else passes++;
      end
      checks++; if (err_o !== 1'b1) $display("FAIL short_err got %b want 1", err_o); else passes++;
      idle(20);
      checks++; if (err_o !== 1'b1) $display("FAIL short_err_sticky got %b want 1", err_o); else passes++;
      for (int i = 0; i < 15; i++) begin
         drive(i, 4, 9, 32'h10);
         tick();
         v = (i >= 9 && i < 13);
         checks++; if (dfi_rvld_o !== v) $display("FAIL refr_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
         checks++; if (dfi_last_o !== (i == 12)) $display("FAIL refr_last step %0d got %b want %b", i, dfi_last_o, (i == 12)); else passes++;
         if (v) begin
            checks++; if (dfi_data_o !== 32'h10 + 32'(i - 9)) $display("FAIL refr_data step %0d got %h want %h", i, dfi_data_o, 32'h10 + 32'(i - 9)); else passes++;
         end
      end
      checks++; if (err_o !== 1'b1) $display("FAIL refr_err got %b want 1", err_o); else passes++;
      idle(20);
   endtask

   task automatic test_reset_midburst();
      logic v;
      for (int i = 0; i < 11; i++) begin
         drive(i, 4, 9, 32'h20);
         tick();
         v = (i >= 9);
         checks++; if (dfi_rvld_o !== v) $display("FAIL mid_rvld step %0d got %b want %b", i, dfi_rvld_o, v); else passes++;
      end
      reset = 1'b1;
      drive(11, 4, 9, 32'h20);
      tick();
      reset = 1'b0;
      dfi_rden_i = 1'b0;
      checks++; if (dfi_rvld_o !== 1'b0) $display("FAIL mid_reset_rvld got %b want 0", dfi_rvld_o); else passes++;
      checks++; if (dfi_last_o !== 1'b0) $display("FAIL mid_reset_last got %b want 0", dfi_last_o); else passes++;
      checks++; if (dfi_data_o !== 32'h0) $display("FAIL mid_reset_data got %h want 0", dfi_data_o); else passes++;
      checks++; if (busy_o !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy_o); else passes++;
      checks++; if (err_o !== 1'b0) $display("FAIL mid_reset_err got %b want 0", err_o); else passes++;
      checks++; if (cfg_delay_o !== 4'd5) $display("FAIL mid_reset_delay got %0d want 5", cfg_delay_o); else passes++;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (dfi_rvld_o !== 1'b0) $display("FAIL post_reset_rvld step %0d got %b want 0", i, dfi_rvld_o); else passes++;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_load_idle();
      test_load_pending();
      test_short_burst();
      test_reset_midburst();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
